// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg
//   Shared types and constants for the bit-serial add/subtract unit.
//   alu_op_e           : opcode encoding on the 'op' port.
//   alu_serial_state_e : control FSM states of alu_serial_addsub.
//   ALU_SERIAL_MAX_WIDTH : upper bound on the WIDTH parameter.
package alu_serial_pkg;

  localparam int unsigned ALU_SERIAL_MAX_WIDTH = 32;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_serial_state_e;

endpackage

// File: rtl/alu_serial_addsub_cell.sv
// serial_bit_cell
//   Combinational 1-bit full adder used one bit per clock by
//   alu_serial_addsub.
//   Ports: a, b, cin (in)  -> s (sum), cout (carry out).
module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/alu_serial_addsub.sv
// alu_serial_addsub
//   Bit-serial WIDTH-bit add/subtract unit. Operands are taken over a
//   valid/ready handshake in IDLE, processed LSB-first through a single
//   serial_bit_cell (one bit per clock in SHIFT), and presented in DONE
//   over a second valid/ready handshake.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//     a, b, op              operands; op 0 = a+b, 1 = a-b
//     out_valid / out_ready result handshake (out_valid high only in DONE)
//     result, cout          sum/difference mod 2^WIDTH, final carry
//                           (for subtract, cout 1 = no borrow)
//     zero, ovf             result==0, signed overflow; only present when
//                           the macro ALU_SERIAL_FLAGS_EN is defined
module alu_serial_addsub
  import alu_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_serial_state_e r_state;
  logic [WIDTH-1:0]  r_a_sr;
  logic [WIDTH-1:0]  r_b_sr;
  logic [WIDTH-1:0]  r_res_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_carry;
  logic [WIDTH-1:0]  r_result;
  logic              r_cout;
`ifdef ALU_SERIAL_FLAGS_EN
  logic              r_zero;
  logic              r_ovf;
`endif

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  serial_bit_cell u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_sum, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1: invert b here, the +1 is the carry-in.
            r_a_sr   <= a;
            r_b_sr   <= (alu_op_e'(op) == ALU_SUB) ? ~b : b;
            r_carry  <= op;
            r_res_sr <= '0;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_res_sr <= w_res_next;
          r_carry  <= w_cout;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            // Visible outputs only change here, so they hold between DONEs
            // and never show a partial result.
            r_result <= w_res_next;
            r_cout   <= w_cout;
`ifdef ALU_SERIAL_FLAGS_EN
            r_zero   <= (w_res_next == '0);
            r_ovf    <= r_carry ^ w_cout;
`endif
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_cout;
`ifdef ALU_SERIAL_FLAGS_EN
  assign zero      = r_zero;
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_addsub.sv
// tb_alu_serial_addsub
//   Self-checking bench for alu_serial_addsub at WIDTH=8. Flag checks are
//   compiled in when ALU_SERIAL_FLAGS_EN is defined.
module tb_alu_serial_addsub;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  alu_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic o);
    exp_t e;
    logic [W:0] s;
    if (o) s = {1'b0, x} - {1'b0, y} + (W+1)'(1 << W);
    else   s = {1'b0, x} + {1'b0, y};
    e.res = s[W-1:0];
    e.co  = s[W];
    e.z   = (s[W-1:0] == '0);
    if (o) e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    else   e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #12;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
    end
    n_tests++;
    if (result !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: result=%h cout=%b, need 00/0", result, cout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b, need 1", in_ready);
    end
  endtask

  task automatic test_arith;
    logic [W-1:0] ta[6] = '{8'h35, 8'h12, 8'h80, 8'hFF, 8'h7F, 8'h00};
    logic [W-1:0] tb[6] = '{8'h12, 8'h35, 8'h01, 8'h01, 8'h01, 8'h00};
    logic         to[6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      int cyc;
      in_valid = 1'b1; a = ta[i]; b = tb[i]; op = to[i];
      sb.push_back(model(ta[i], tb[i], to[i]));
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_tests++;
      if (cyc != W) begin
        n_fail++;
        $display("FAIL arith_latency[%0d]: %0d cycles, need %0d", i, cyc, W);
      end
      e = sb.pop_front();
      n_tests++;
      if (result !== e.res || cout !== e.co) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: %h cout=%b, need %h cout=%b",
                 i, result, cout, e.res, e.co);
      end
`ifdef ALU_SERIAL_FLAGS_EN
      n_tests++;
      if (zero !== e.z || ovf !== e.v) begin
        n_fail++;
        $display("FAIL arith_flags[%0d]: zero=%b ovf=%b, need %b/%b", i, zero, ovf, e.z, e.v);
      end
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_return[%0d]: in_ready=%b out_valid=%b, need 1/0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int cyc;
    in_valid = 1'b1; a = 8'h5A; b = 8'h21; op = 1'b0;
    sb.push_back(model(8'h5A, 8'h21, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || cout !== e.co) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b res=%h co=%b, need 1/0/%h/%b",
                 k, out_valid, in_ready, result, cout, e.res, e.co);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== e.res) begin
      n_fail++;
      $display("FAIL bp_release: ir=%b ov=%b res=%h, need 1/0/%h",
               in_ready, out_valid, result, e.res);
    end
    // Stay idle a few cycles: a captured stray operand would leave IDLE.
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || result !== e.res) begin
      n_fail++;
      $display("FAIL bp_ignored: ir=%b res=%h, need 1/%h", in_ready, result, e.res);
    end
  endtask

  task automatic test_reset_midop;
    exp_t e;
    int cyc;
    in_valid = 1'b1; a = 8'h9C; b = 8'h37; op = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: ov=%b res=%h ir=%b, need 0/00/1", out_valid, result, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h01; b = 8'h01; op = 1'b0;
    sb.push_back(model(8'h01, 8'h01, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    n_tests++;
    if (cyc != W || result !== e.res || result !== 8'h02) begin
      n_fail++;
      $display("FAIL after_reset_add: res=%h lat=%0d, need 02 lat=%0d", result, cyc, W);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ba[3] = '{8'hA5, 8'h10, 8'hC3};
    logic [W-1:0] bb[3] = '{8'h5B, 8'h20, 8'h3C};
    logic         bo[3] = '{1'b0,  1'b1,  1'b1};
    int idx = 0;
    int n_out = 0;
    int last_cyc = -1;
    int cyc = 0;
    logic pre_ready;
    in_valid = 1'b1; a = ba[0]; b = bb[0]; op = bo[0];
    sb.push_back(model(ba[0], bb[0], bo[0]));
    out_ready = 1'b1;
    while (n_out < 3 && cyc < 200) begin
      pre_ready = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (pre_ready && in_valid) begin
        idx++;
        if (idx < 3) begin
          a = ba[idx]; b = bb[idx]; op = bo[idx];
          sb.push_back(model(ba[idx], bb[idx], bo[idx]));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (result !== e.res || cout !== e.co) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: %h cout=%b, need %h cout=%b",
                   n_out, result, cout, e.res, e.co);
        end
        if (last_cyc >= 0) begin
          n_tests++;
          if (cyc - last_cyc != W + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: %0d cycles, need %0d", n_out, cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        n_out++;
      end
    end
    n_tests++;
    if (n_out != 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, need 3", n_out);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
